switch_event_decoder: RTL and testbench



---
 rtl/switch_event_decoder_pkg.sv | 16 +
 rtl/switch_event_decoder_event_timer.sv | 34 +++
 rtl/switch_event_decoder.sv | 137 +++++++++++++
 tb/tb_switch_event_decoder.sv | 127 ++++++++++++
 4 files changed

// File: rtl/switch_event_decoder_pkg.sv
// Shared FSM encodings and default timing constants for the switch event decoder.
package switch_event_pkg;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PRESSED = 2'd1;
   localparam logic [1:0] HELD    = 2'd2;

   localparam int unsigned DEFAULT_LONG_CYCLES   = 25000000;
   localparam int unsigned DEFAULT_REPEAT_CYCLES = 5000000;
   localparam int unsigned DEFAULT_COUNT_WIDTH   = 4;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/switch_event_decoder_event_timer.sv
// Clearable up-counter with a terminal-count compare against a runtime-selected limit.
module event_timer #(
   parameter int unsigned Width = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             enable_i,
   input  logic [Width-1:0] limit_i,
   output logic             match_o
);

   logic [Width-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign match_o = (count_q == limit_i);

endmodule

// File: rtl/switch_event_decoder.sv
// Turns a debounced switch level into press/release/long/repeat pulses and a wrapping event count.
module switch_event_decoder
   import switch_event_pkg::*;
#(
   parameter int unsigned c_LONG_CYCLES   = DEFAULT_LONG_CYCLES,
   parameter int unsigned c_REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES,
   parameter int unsigned c_COUNT_WIDTH   = DEFAULT_COUNT_WIDTH
) (
   input  logic                     i_Clk,
   input  logic                     i_Rst,
   input  logic                     i_Switch,
   output logic                     o_Press,
   output logic                     o_Release,
   output logic                     o_Long,
   output logic                     o_Repeat,
   output logic                     o_Held,
   output logic [c_COUNT_WIDTH-1:0] o_Count
);

   localparam int unsigned TimerWidth = $clog2(max_u(c_LONG_CYCLES, c_REPEAT_CYCLES));
   localparam logic [TimerWidth-1:0] LongLimit   = TimerWidth'(c_LONG_CYCLES - 1);
   localparam logic [TimerWidth-1:0] RepeatLimit = TimerWidth'(c_REPEAT_CYCLES - 1);

   logic [1:0]               state_d, state_q;
   logic                     prev_q;
   logic                     press_d, press_q;
   logic                     release_d, release_q;
   logic                     long_d, long_q;
   logic                     repeat_d, repeat_q;
   logic                     held_d, held_q;
   logic [c_COUNT_WIDTH-1:0] count_d, count_q;

   logic                     rise, fall;
   logic                     timer_clear, timer_enable, timer_match;
   logic [TimerWidth-1:0]    timer_limit;

   assign rise        = i_Switch & ~prev_q;
   assign fall        = ~i_Switch & prev_q;
   assign timer_limit = (state_q == HELD) ? RepeatLimit : LongLimit;

   event_timer #(
      .Width (TimerWidth)
   ) u_event_timer (
      .clk_i    (i_Clk),
      .rst_i    (i_Rst),
      .clear_i  (timer_clear),
      .enable_i (timer_enable),
      .limit_i  (timer_limit),
      .match_o  (timer_match)
   );

   // Falling edge is tested first so a release always beats a coincident timer match.
   always_comb begin
      state_d      = state_q;
      press_d      = 1'b0;
      release_d    = 1'b0;
      long_d       = 1'b0;
      repeat_d     = 1'b0;
      held_d       = held_q;
      count_d      = count_q;
      timer_clear  = 1'b0;
      timer_enable = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d     = PRESSED;
               press_d     = 1'b1;
               count_d     = count_q + 1'b1;
               timer_clear = 1'b1;
            end
         end
         PRESSED: begin
            if (fall) begin
               state_d     = IDLE;
               release_d   = 1'b1;
               timer_clear = 1'b1;
            end else if (timer_match) begin
               state_d     = HELD;
               long_d      = 1'b1;
               held_d      = 1'b1;
               timer_clear = 1'b1;
            end else if (i_Switch) begin
               timer_enable = 1'b1;
            end
         end
         HELD: begin
            if (fall) begin
               state_d     = IDLE;
               release_d   = 1'b1;
               held_d      = 1'b0;
               timer_clear = 1'b1;
            end else if (timer_match) begin
               repeat_d    = 1'b1;
               count_d     = count_q + 1'b1;
               timer_clear = 1'b1;
            end else if (i_Switch) begin
               timer_enable = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            held_d      = 1'b0;
            timer_clear = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q   <= IDLE;
         prev_q    <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
         held_q    <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         prev_q    <= i_Switch;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
         held_q    <= held_d;
         count_q   <= count_d;
      end
   end

   assign o_Press   = press_q;
   assign o_Release = release_q;
   assign o_Long    = long_q;
   assign o_Repeat  = repeat_q;
   assign o_Held    = held_q;
   assign o_Count   = count_q;

endmodule

// File: tb/tb_switch_event_decoder.sv
// Directed self-checking bench for switch_event_decoder with short timing thresholds.
module tb_switch_event_decoder;

   logic       clk;
   logic       rst;
   logic       sw;
   logic       press, rel, lng, rpt, held;
   logic [3:0] count;

   int n_checks = 0;
   int n_pass   = 0;

   switch_event_decoder #(
      .c_LONG_CYCLES   (8),
      .c_REPEAT_CYCLES (4),
      .c_COUNT_WIDTH   (4)
   ) dut (
      .i_Clk     (clk),
      .i_Rst     (rst),
      .i_Switch  (sw),
      .o_Press   (press),
      .o_Release (rel),
      .o_Long    (lng),
      .o_Repeat  (rpt),
      .o_Held    (held),
      .o_Count   (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag, input logic ep, input logic er, input logic el,
                            input logic erp, input logic eh, input logic [3:0] ec);
      check({tag, ".press"},   press, ep);
      check({tag, ".release"}, rel,   er);
      check({tag, ".long"},    lng,   el);
      check({tag, ".repeat"},  rpt,   erp);
      check({tag, ".held"},    held,  eh);
      check({tag, ".count"},   count, ec);
      check({tag, ".onehot"},  ($countones({press, rel, lng, rpt}) <= 1), 1);
   endtask

   // Drive the switch, clock one edge, then check outputs 1 time unit after it.
   task automatic step(input string tag, input logic s, input logic ep, input logic er,
                       input logic el, input logic erp, input logic eh, input logic [3:0] ec);
      sw = s;
      @(posedge clk);
      #1;
      check_all(tag, ep, er, el, erp, eh, ec);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sw  = 1'b0;
      @(posedge clk);
      #1;
      check_all("reset", 0, 0, 0, 0, 0, 4'd0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      sw  = 1'b0;
      #3;
      check_all("por", 0, 0, 0, 0, 0, 4'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Short press: three cycles high
      step("short0", 1, 1, 0, 0, 0, 0, 4'd1);
      step("short1", 1, 0, 0, 0, 0, 0, 4'd1);
      step("short2", 1, 0, 0, 0, 0, 0, 4'd1);
      step("short_rel", 0, 0, 1, 0, 0, 0, 4'd1);
      step("short_idle", 0, 0, 0, 0, 0, 0, 4'd1);

      // Long hold: 20 cycles high, long at +8, repeats at +12/+16, release wins at +20
      do_reset();
      for (int i = 0; i < 20; i++) begin
         automatic logic [3:0] ec = 4'd1 + ((i >= 12) ? 4'd1 : 4'd0) + ((i >= 16) ? 4'd1 : 4'd0);
         step($sformatf("hold%0d", i), 1, (i == 0), 0, (i == 8), (i == 12 || i == 16),
              (i >= 8), ec);
      end
      step("hold_rel", 0, 0, 1, 0, 0, 0, 4'd3);
      step("hold_idle", 0, 0, 0, 0, 0, 0, 4'd3);

      // Falling edge lands on the long-press threshold
      do_reset();
      step("coin0", 1, 1, 0, 0, 0, 0, 4'd1);
      for (int i = 1; i < 8; i++) step($sformatf("coin%0d", i), 1, 0, 0, 0, 0, 0, 4'd1);
      step("coin_rel", 0, 0, 1, 0, 0, 0, 4'd1);
      step("coin_after", 0, 0, 0, 0, 0, 0, 4'd1);

      // Counter wrap over 17 short presses
      do_reset();
      for (int n = 1; n <= 17; n++) begin
         step($sformatf("wrap_p%0d", n), 1, 1, 0, 0, 0, 0, 4'(n % 16));
         step($sformatf("wrap_r%0d", n), 0, 0, 1, 0, 0, 0, 4'(n % 16));
      end

      // Reset asserted mid-hold, switch stays high through deassertion
      do_reset();
      for (int i = 0; i < 10; i++)
         step($sformatf("mid%0d", i), 1, (i == 0), 0, (i == 8), 0, (i >= 8), 4'd1);
      #2;
      rst = 1'b1;
      #1;
      check_all("async_rst", 0, 0, 0, 0, 0, 4'd0);
      @(posedge clk);
      #1;
      check_all("rst_hold", 0, 0, 0, 0, 0, 4'd0);
      rst = 1'b0;
      step("post_rst_press", 1, 1, 0, 0, 0, 0, 4'd1);
      step("post_rst_hi", 1, 0, 0, 0, 0, 0, 4'd1);
      step("post_rst_rel", 0, 0, 1, 0, 0, 0, 4'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
